// File: rtl/intr_ctrl.sv
// Interrupt controller: NUM_SRC level/edge external sources, prescaled machine timer, software bit.
// Optional macro INTR_CTRL_SYNC_EN adds a 2-flop synchroniser on src_i.
module intr_ctrl #(
  parameter int NUM_SRC    = 8,
  parameter int TIMER_W    = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               cfg_write,
  input  logic [2:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic               cfg_rvalid,
  output logic [31:0]        cfg_rdata,
  output logic               timerInterrupt,
  output logic               externalInterrupt,
  output logic               softwareInterrupt
);

  logic [NUM_SRC-1:0]    srcIn, srcQ, edgePend, enable, mode;
  logic [NUM_SRC-1:0]    pend, active, edgeClr, claimMask;
  logic [TIMER_W-1:0]    mtime, mtimecmp;
  logic [PRESCALE_W-1:0] prescale, presCnt;
  logic                  msip, accept, wrEn, rdEn, timerTick;
  logic [31:0]           claimId, readValue;

`ifdef INTR_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] syncA, syncB;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= src_i;
      syncB <= syncA;
    end
  end

  assign srcIn = syncB;
`else
  assign srcIn = src_i;
`endif

  assign pend      = (mode & edgePend) | (~mode & srcQ);
  assign active    = pend & enable;
  assign accept    = cfg_valid && cfg_ready;
  assign wrEn      = accept && cfg_write;
  assign rdEn      = accept && !cfg_write;
  assign timerTick = (presCnt == prescale);

  // Descending scan so the lowest-index active source is the one left standing.
  always_comb begin
    claimId   = '0;
    claimMask = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claimId      = 32'(i + 1);
        claimMask    = '0;
        claimMask[i] = 1'b1;
      end
    end
  end

  // Edge-pending clears: W1C, claim of an edge source, or a source leaving edge mode.
  always_comb begin
    edgeClr = '0;
    if (wrEn && cfg_addr == 3'd1) edgeClr = mode & ~cfg_wdata[NUM_SRC-1:0];
    if (wrEn && cfg_addr == 3'd2) edgeClr = cfg_wdata[NUM_SRC-1:0];
    if (rdEn && cfg_addr == 3'd3) edgeClr = claimMask & mode;
  end

  always_comb begin
    readValue = '0;
    case (cfg_addr)
      3'd0: readValue = 32'(enable);
      3'd1: readValue = 32'(mode);
      3'd2: readValue = 32'(pend);
      3'd3: readValue = claimId;
      3'd4: readValue = 32'(mtime);
      3'd5: readValue = 32'(mtimecmp);
      3'd6: readValue = {31'b0, msip};
      3'd7: readValue = 32'(prescale);
      default: readValue = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      srcQ     <= '0;
      edgePend <= '0;
      enable   <= '0;
      mode     <= '0;
      msip     <= 1'b0;
    end else begin
      srcQ     <= srcIn;
      edgePend <= (edgePend & ~edgeClr) | (srcIn & ~srcQ);
      if (wrEn && cfg_addr == 3'd0) enable <= cfg_wdata[NUM_SRC-1:0];
      if (wrEn && cfg_addr == 3'd1) mode   <= cfg_wdata[NUM_SRC-1:0];
      if (wrEn && cfg_addr == 3'd6) msip   <= cfg_wdata[0];
    end
  end

  // A register write to MTIME overrides the same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      prescale <= '0;
      presCnt  <= '0;
    end else begin
      if (wrEn && cfg_addr == 3'd7) begin
        prescale <= cfg_wdata[PRESCALE_W-1:0];
        presCnt  <= '0;
      end else if (timerTick) begin
        presCnt <= '0;
      end else begin
        presCnt <= presCnt + 1'b1;
      end
      if (wrEn && cfg_addr == 3'd4) mtime <= cfg_wdata[TIMER_W-1:0];
      else if (timerTick)           mtime <= mtime + 1'b1;
      if (wrEn && cfg_addr == 3'd5) mtimecmp <= cfg_wdata[TIMER_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready         <= 1'b1;
      cfg_rvalid        <= 1'b0;
      cfg_rdata         <= '0;
      timerInterrupt    <= 1'b0;
      externalInterrupt <= 1'b0;
      softwareInterrupt <= 1'b0;
    end else begin
      cfg_ready         <= !accept;
      cfg_rvalid        <= rdEn;
      if (rdEn) cfg_rdata <= readValue;
      timerInterrupt    <= (mtime >= mtimecmp);
      externalInterrupt <= |active;
      softwareInterrupt <= msip;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic against a
// cycle-indexed reference model (closed-form timer, latched-edge source bookkeeping).
module tb_intr_ctrl;
  localparam int N = 8;

  logic          clk;
  logic          reset;
  logic [N-1:0]  src_i;
  logic          cfg_valid, cfg_ready, cfg_write, cfg_rvalid;
  logic [2:0]    cfg_addr;
  logic [31:0]   cfg_wdata, cfg_rdata;
  logic          timerInterrupt, externalInterrupt, softwareInterrupt;

  intr_ctrl #(.NUM_SRC(N), .TIMER_W(32), .PRESCALE_W(8)) dut (
    .clk(clk), .reset(reset), .src_i(src_i),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_write(cfg_write),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rvalid(cfg_rvalid),
    .cfg_rdata(cfg_rdata), .timerInterrupt(timerInterrupt),
    .externalInterrupt(externalInterrupt), .softwareInterrupt(softwareInterrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int unsigned cyc, tBaseCyc, tPresCyc;
  logic [31:0] tBase, mCmp, mRdata;
  logic [7:0]  tP;
  logic [N-1:0] mEn, mMode, mLatch, mLast;
  logic [N-1:0] srcDly [2];
  logic mExt, mTmr, mSw, mMsip, mRvalid;
  logic reqWr, reqRd;
  logic [2:0]  reqAddr;
  logic [31:0] reqData;

  // mtime after edge c: base plus the number of prescale periods completed since the base point.
  function automatic logic [31:0] expMtime(int unsigned c);
    int unsigned per;
    per = 32'(tP) + 1;
    return tBase + (c - tPresCyc) / per - (tBaseCyc - tPresCyc) / per;
  endfunction

  function automatic logic [31:0] claimValue(logic [N-1:0] act);
    for (int i = 0; i < N; i++) if (act[i]) return 32'(i + 1);
    return 32'd0;
  endfunction

  task automatic modelReset();
    mEn = '0; mMode = '0; mLatch = '0; mLast = '0;
    srcDly[0] = '0; srcDly[1] = '0;
    mExt = 0; mTmr = 0; mSw = 0; mMsip = 0; mRvalid = 0; mRdata = '0;
    mCmp = '1; tP = '0; tBase = '0; tBaseCyc = 0; tPresCyc = 0; cyc = 0;
    reqWr = 0; reqRd = 0; reqAddr = '0; reqData = '0;
  endtask

  task automatic checkVal(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, applying the effect of the inputs currently presented.
  task automatic tick();
    logic [N-1:0] srcView, pendV, clr, rise;
    logic [31:0]  rv;
    logic         nExt, nTmr, nSw, nRv;
`ifdef INTR_CTRL_SYNC_EN
    srcView = srcDly[1];
`else
    srcView = src_i;
`endif
    pendV = (mMode & mLatch) | (~mMode & mLast);
    clr   = '0;
    rv    = mRdata;
    nRv   = reqRd;
    if (reqRd) begin
      case (reqAddr)
        3'd0: rv = 32'(mEn);
        3'd1: rv = 32'(mMode);
        3'd2: rv = 32'(pendV);
        3'd3: begin
          rv = claimValue(pendV & mEn);
          if (rv != 0) clr[rv - 1] = mMode[rv - 1];
        end
        3'd4: rv = expMtime(cyc);
        3'd5: rv = mCmp;
        3'd6: rv = {31'b0, mMsip};
        default: rv = 32'(tP);
      endcase
    end
    nExt = |(pendV & mEn);
    nTmr = (expMtime(cyc) >= mCmp);
    nSw  = mMsip;
    if (reqWr) begin
      case (reqAddr)
        3'd0: mEn = reqData[N-1:0];
        3'd1: begin
          clr   = clr | (mMode & ~reqData[N-1:0]);
          mMode = reqData[N-1:0];
        end
        3'd2: clr = clr | reqData[N-1:0];
        3'd4: begin tBase = reqData; tBaseCyc = cyc + 1; end
        3'd5: mCmp = reqData;
        3'd6: mMsip = reqData[0];
        3'd7: begin
          tBase = expMtime(cyc + 1);
          tBaseCyc = cyc + 1; tPresCyc = cyc + 1; tP = reqData[7:0];
        end
        default: ;
      endcase
    end
    rise   = srcView & ~mLast;
    mLatch = (mLatch & ~clr) | rise;
    mLast  = srcView;
    srcDly[1] = srcDly[0];
    srcDly[0] = src_i;
    reqWr = 0; reqRd = 0;
    @(posedge clk);
    #1;
    cyc++;
    mExt = nExt; mTmr = nTmr; mSw = nSw; mRvalid = nRv; mRdata = rv;
  endtask

  task automatic checkOutput();
    checkVal("extInt", externalInterrupt, mExt);
    checkVal("timerInt", timerInterrupt, mTmr);
    checkVal("swInt", softwareInterrupt, mSw);
    checkVal("rvalid", cfg_rvalid, mRvalid);
    checkVal("rdata", cfg_rdata, mRdata);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v);
    src_i = v;
    tick();
    checkOutput();
  endtask

  task automatic cfgWrite(input logic [2:0] addr, input logic [31:0] data);
    cfg_valid = 1; cfg_write = 1; cfg_addr = addr; cfg_wdata = data;
    reqWr = 1; reqAddr = addr; reqData = data;
    tick();
    cfg_valid = 0; cfg_write = 0;
    checkVal("readyLowAfterWrite", cfg_ready, 0);
    checkOutput();
    tick();
    checkVal("readyBack", cfg_ready, 1);
    checkOutput();
  endtask

  task automatic cfgRead(input logic [2:0] addr, output logic [31:0] data);
    cfg_valid = 1; cfg_write = 0; cfg_addr = addr;
    reqRd = 1; reqAddr = addr;
    tick();
    cfg_valid = 0;
    checkVal("readyLowAfterRead", cfg_ready, 0);
    checkOutput();
    data = cfg_rdata;
    tick();
    checkVal("readyBack", cfg_ready, 1);
    checkOutput();
  endtask

  initial begin
    logic [31:0] d;
    reset = 1; src_i = '0; cfg_valid = 0; cfg_write = 0; cfg_addr = '0; cfg_wdata = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkVal("resetReady", cfg_ready, 1);
    checkOutput();
    reset = 0;

    // Register map after reset.
    for (int a = 0; a < 8; a++) begin
      cfgRead(3'(a), d);
      if (a == 5) checkVal("resetMtimecmp", d, 32'hFFFF_FFFF);
      if (a == 0) checkVal("resetEnable", d, 0);
    end

    // Edge source 2: latency, claim, claim clears.
    cfgWrite(3'd0, 32'h0C);
    cfgWrite(3'd1, 32'h04);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
`ifdef INTR_CTRL_SYNC_EN
    repeat (2) applyStimulus(8'h00);
`endif
    checkVal("edgeLatency", externalInterrupt, 1);
    cfgRead(3'd3, d);
    checkVal("claimEdge", d, 3);
    cfgRead(3'd3, d);
    checkVal("claimEmpty", d, 0);

    // Level source 3: repeated claim, W1C has no effect, drop clears.
    repeat (4) applyStimulus(8'h08);
    cfgRead(3'd3, d);
    checkVal("claimLevel1", d, 4);
    cfgRead(3'd3, d);
    checkVal("claimLevel2", d, 4);
    cfgWrite(3'd2, 32'h08);
    cfgRead(3'd2, d);
    checkVal("levelIgnoresW1c", d, 32'h08);
    repeat (4) applyStimulus(8'h00);
    checkVal("levelDropped", externalInterrupt, 0);

    // Prescaled timer against compare.
    cfgWrite(3'd7, 32'd3);
    cfgWrite(3'd5, 32'd5);
    cfgWrite(3'd4, 32'd0);
    repeat (30) applyStimulus(8'h00);
    checkVal("timerFired", timerInterrupt, 1);
    cfgWrite(3'd5, 32'd100);
    checkVal("timerCleared", timerInterrupt, 0);

    // mtime wrap.
    cfgWrite(3'd7, 32'd0);
    cfgWrite(3'd4, 32'hFFFF_FFFE);
    cfgRead(3'd4, d);
    checkVal("mtimeAllOnes", d, 32'hFFFF_FFFF);
    cfgRead(3'd4, d);
    checkVal("mtimeWrapped", d, 32'd1);

    // W1C and a new edge on source 0 in the same cycle: the set wins.
    cfgWrite(3'd1, 32'h05);
    cfg_valid = 1; cfg_write = 1; cfg_addr = 3'd2; cfg_wdata = 32'h01;
    reqWr = 1; reqAddr = 3'd2; reqData = 32'h01;
    src_i = 8'h01;
    tick();
    cfg_valid = 0; cfg_write = 0;
    checkOutput();
    tick();
    checkOutput();
    repeat (3) applyStimulus(8'h01);
    cfgRead(3'd2, d);
    checkVal("setWinsOverW1c", d[0], 1);

    cfgWrite(3'd6, 32'd1);
    checkVal("softwareInt", softwareInterrupt, 1);

    // Random traffic.
    repeat (200) begin
      case ($urandom_range(0, 3))
        0, 1: applyStimulus(N'($urandom));
        2: begin
          logic [2:0] a;
          a = 3'($urandom_range(0, 7));
          cfgWrite(a, (a == 3'd7) ? 32'($urandom_range(0, 3)) : $urandom);
        end
        default: cfgRead(3'($urandom_range(0, 7)), d);
      endcase
    end

    // Reset while a read request is presented.
    cfg_valid = 1; cfg_write = 0; cfg_addr = 3'd5;
    #2 reset = 1;
    #1;
    modelReset();
    checkVal("midResetReady", cfg_ready, 1);
    checkOutput();
    cfg_valid = 0; src_i = '0;
    @(posedge clk);
    #1;
    reset = 0;
    checkOutput();
    for (int a = 0; a < 8; a++) begin
      cfgRead(3'(a), d);
      if (a == 5) checkVal("postResetMtimecmp", d, 32'hFFFF_FFFF);
      if (a == 1) checkVal("postResetMode", d, 0);
      if (a == 6) checkVal("postResetMsip", d, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
